// File: rtl/sram_pio_ctrl_if.sv
// Request/response bundle between a host and the SRAM programmed-I/O controller.
interface sram_pio_ctrl_if;
    logic [10:0] sram_address;
    logic [7:0]  sram_datain;
    logic        sram_enable;
    logic        sram_readwrite;
    logic [7:0]  sram_dataout;
    logic        sram_busy;
    logic        sram_done;

    modport master (
        output sram_address,
        output sram_datain,
        output sram_enable,
        output sram_readwrite,
        input  sram_dataout,
        input  sram_busy,
        input  sram_done
    );

    modport slave (
        input  sram_address,
        input  sram_datain,
        input  sram_enable,
        input  sram_readwrite,
        output sram_dataout,
        output sram_busy,
        output sram_done
    );
endinterface

// File: rtl/sram_pio_ctrl.sv
// SRAM programmed-I/O controller: a rising edge on sram_enable starts one
// latched read or write of an internal DEPTH x 8 synchronous memory.
module sram_pio_ctrl #(
    parameter int unsigned DEPTH = 2048
) (
    input logic           clk_clk,
    input logic           reset_reset_n,
    sram_pio_ctrl_if.slave sram
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        en_q;
    logic        req;
    logic [10:0] addr_r;
    logic [7:0]  data_r;
    logic        rw_r;
    logic [7:0]  dout_r;
    logic [7:0]  mem [DEPTH];

    // State register and enable history; en_q resets high so an enable held
    // through reset release is not mistaken for a new request.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= ST_IDLE;
            en_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            en_q  <= sram.sram_enable;
        end
    end

    // Next-state logic and status outputs decoded from the current state.
    always_comb begin
        state_nxt      = state;
        req            = sram.sram_enable && !en_q;
        sram.sram_busy = 1'b0;
        sram.sram_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                sram.sram_busy = 1'b1;
                state_nxt      = ST_ACCESS;
            end
            ST_ACCESS: begin
                sram.sram_busy = 1'b1;
                state_nxt      = ST_DONE;
            end
            ST_DONE: begin
                sram.sram_done = 1'b1;
                if (!sram.sram_enable) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture in LATCH and read-data register loaded only by a read ACCESS.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_r <= '0;
            data_r <= '0;
            rw_r   <= 1'b0;
            dout_r <= '0;
        end else begin
            if (state == ST_LATCH) begin
                addr_r <= sram.sram_address;
                data_r <= sram.sram_datain;
                rw_r   <= sram.sram_readwrite;
            end
            if (state == ST_ACCESS && rw_r) begin
                dout_r <= mem[addr_r];
            end
        end
    end

    // Memory array write port; deliberately not reset so contents survive reset.
    always_ff @(posedge clk_clk) begin
        if (state == ST_ACCESS && !rw_r) begin
            mem[addr_r] <= data_r;
        end
    end

    assign sram.sram_dataout = dout_r;

endmodule

// File: doc/sram_pio_ctrl.md
SRAM_PIO_CTRL -- requirements
Module: sram_pio_ctrl

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 Port clk_clk, input, 1: system clock; all state SHALL update on its rising edge.
REQ-003 Port reset_reset_n, input, 1: asynchronous active-low reset.
REQ-004 Port sram_address, input, 11: word address, 0..2047.
REQ-005 Port sram_datain, input, 8: write data.
REQ-006 Port sram_enable, input, 1: request strobe; a request is its 0->1 transition.
REQ-007 Port sram_readwrite, input, 1: 1 = read, 0 = write.
REQ-008 Port sram_dataout, output, 8: registered read data.
REQ-009 Port sram_busy, output, 1: high while an access is in progress (LATCH or ACCESS).
REQ-010 Port sram_done, output, 1: high while in DONE.
REQ-011 Parameter DEPTH, default 2048: number of 8-bit words; address width SHALL stay 11.

Function
REQ-012 The block SHALL contain an internal DEPTH x 8 synchronous memory array; contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.
REQ-013 Register en_q SHALL hold sram_enable delayed one cycle; a request SHALL be detected when sram_enable=1 and en_q=0.
REQ-014 FSM states: IDLE, LATCH, ACCESS, DONE.
REQ-015 IDLE: on a detected request -> LATCH; otherwise stay; sram_busy=0, sram_done=0.
REQ-016 LATCH: capture sram_address, sram_datain and sram_readwrite into internal registers; -> ACCESS unconditionally.
REQ-017 ACCESS: write -> mem[addr_r] <= data_r; read -> sram_dataout <= mem[addr_r]; -> DONE unconditionally.
REQ-018 DONE: sram_done=1; stay while sram_enable=1; -> IDLE in the first cycle sram_enable=0.
REQ-019 Latency: request detected at edge N -> LATCH at N+1 -> ACCESS at N+2 -> sram_done high and read data valid from edge N+3.
REQ-020 sram_dataout SHALL change only in ACCESS of a read; writes and idle cycles SHALL hold the last read value.
REQ-021 Input changes after LATCH SHALL NOT affect the in-flight access.
REQ-022 sram_enable falling during LATCH or ACCESS SHALL NOT abort the access; DONE SHALL still be entered for at least one cycle.
REQ-023 sram_enable re-rising while not in IDLE SHALL be ignored; no request SHALL be queued.
REQ-024 A read following a write to the same address SHALL return the newly written value.
REQ-025 Addresses 0 and 2047 SHALL be fully accessible; no wrap or aliasing within 0..DEPTH-1.

Reset
REQ-026 On reset_reset_n=0: state=IDLE, sram_dataout=8'h00, sram_busy=0, sram_done=0, en_q=1, latched registers=0.
REQ-027 en_q=1 at reset SHALL ensure sram_enable held high through reset release produces no access until it goes low and rises again.
REQ-028 Reset asserted mid-access SHALL abort immediately; a write not yet in ACCESS SHALL NOT modify memory.

Verification
REQ-029 Write 8'hA5 to address 11'h000, then read 11'h000 -> sram_dataout=8'hA5 with sram_done high 3 cycles after the enable edge.
REQ-030 Write 8'h3C to 11'h7FF and 8'hC3 to 11'h000, read both -> 8'h3C and 8'hC3 (no aliasing at boundaries).
REQ-031 Read 11'h010 (8'h55), then write 8'hFF to 11'h020 -> sram_dataout stays 8'h55 through the write.
REQ-032 Hold sram_enable=1 across reset release -> no busy/done; drop and raise with read 11'h000 -> one access only.
REQ-033 Raise enable for one cycle, change address/data in LATCH+1 -> access uses the originally latched values; sram_done pulses one cycle then IDLE.
REQ-034 Assert reset during ACCESS of a write of 8'h99 to 11'h005 previously holding 8'h11 -> outputs reset values; a later read returns 8'h11 or 8'h99, never any other value.
